// File: rtl/axi4lite_pkg.sv
// Shared response codes and FSM state encodings for the AXI4-Lite controller.
package axi4lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_MEM,
        W_RESP
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_MEM,
        R_CAP,
        R_RESP
    } r_state_t;

endpackage

// File: rtl/axi4lite_ctrl.sv
// AXI4-Lite slave channel controller: sequences single-cycle strobes into an
// external byte-strobed memory, range-checks addresses and returns OKAY/SLVERR.
// One outstanding write and one outstanding read; a read that collides with a
// same-word write is held back one cycle so it returns the new data.
module axi4lite_ctrl
    import axi4lite_pkg::*;
#(
    parameter int unsigned addrWidth = 12,
    parameter int unsigned dataWidth = 32,
    parameter int unsigned strbWidth = dataWidth / 8,
    parameter int unsigned memBytes  = 1024
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 AWVALID,
    output logic                 AWREADY,
    input  logic [addrWidth-1:0] AWADDR,

    input  logic                 WVALID,
    output logic                 WREADY,
    input  logic [dataWidth-1:0] WDATA,
    input  logic [strbWidth-1:0] WSTRB,

    output logic                 BVALID,
    input  logic                 BREADY,
    output logic [1:0]           BRESP,

    input  logic                 ARVALID,
    output logic                 ARREADY,
    input  logic [addrWidth-1:0] ARADDR,

    output logic                 RVALID,
    input  logic                 RREADY,
    output logic [dataWidth-1:0] RDATA,
    output logic [1:0]           RRESP,

    output logic                 memWEN,
    output logic [addrWidth-1:0] memAWADDR,
    output logic [strbWidth-1:0] memWSTRB,
    output logic [dataWidth-1:0] memWDATA,

    output logic                 memREN,
    output logic [addrWidth-1:0] memARADDR,
    input  logic [dataWidth-1:0] memRDATA
);

    // ---------------- write channel ----------------
    w_state_t               w_state;
    w_state_t               w_state_next;
    logic                   aw_got;
    logic                   aw_got_next;
    logic                   w_got;
    logic                   w_got_next;
    logic [addrWidth-1:0]   aw_addr;
    logic [dataWidth-1:0]   w_data;
    logic [strbWidth-1:0]   w_strb;
    logic                   aw_fire;
    logic                   w_fire;
    logic                   aw_in_range;

    assign aw_fire     = AWVALID && AWREADY;
    assign w_fire      = WVALID && WREADY;
    assign aw_in_range = (32'(aw_addr) < memBytes);

    // Write next-state: AW and W latch independently; both present -> memory cycle.
    always_comb begin
        w_state_next = w_state;
        aw_got_next  = aw_got;
        w_got_next   = w_got;
        case (w_state)
            W_IDLE: begin
                if (aw_fire) aw_got_next = 1'b1;
                if (w_fire)  w_got_next  = 1'b1;
                if (aw_got_next && w_got_next) begin
                    w_state_next = W_MEM;
                    aw_got_next  = 1'b0;
                    w_got_next   = 1'b0;
                end
            end
            W_MEM:   w_state_next = W_RESP;
            W_RESP:  if (BREADY) w_state_next = W_IDLE;
            default: w_state_next = W_IDLE;
        endcase
    end

    // Write state register; READY is registered from the next state so it is
    // low during reset and rises on the first edge after reset releases.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state <= W_IDLE;
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
        end else begin
            w_state <= w_state_next;
            aw_got  <= aw_got_next;
            w_got   <= w_got_next;
            AWREADY <= (w_state_next == W_IDLE) && !aw_got_next;
            WREADY  <= (w_state_next == W_IDLE) && !w_got_next;
        end
    end

    // Write datapath: capture address/data/strobe and settle the response code.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aw_addr <= '0;
            w_data  <= '0;
            w_strb  <= '0;
            BRESP   <= RESP_OKAY;
        end else begin
            if (aw_fire) aw_addr <= AWADDR;
            if (w_fire) begin
                w_data <= WDATA;
                w_strb <= WSTRB;
            end
            if (w_state == W_MEM) BRESP <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
        end
    end

    assign BVALID    = (w_state == W_RESP);
    assign memWEN    = (w_state == W_MEM) && aw_in_range;
    assign memAWADDR = aw_addr;
    assign memWDATA  = w_data;
    assign memWSTRB  = w_strb;

    // ---------------- read channel ----------------
    r_state_t               r_state;
    r_state_t               r_state_next;
    logic [addrWidth-1:0]   ar_addr;
    logic                   ar_fire;
    logic                   ar_in_range;
    logic                   same_word;
    logic                   ren;

    assign ar_fire     = ARVALID && ARREADY;
    assign ar_in_range = (32'(ar_addr) < memBytes);
    assign same_word   = (aw_addr[addrWidth-1:2] == ar_addr[addrWidth-1:2]);

    // Read next-state: a read that would coincide with a same-word write waits
    // in R_MEM so the memory sees the write first.
    always_comb begin
        r_state_next = r_state;
        ren          = 1'b0;
        case (r_state)
            R_IDLE: if (ar_fire) r_state_next = R_MEM;
            R_MEM: begin
                if (!ar_in_range) begin
                    r_state_next = R_RESP;
                end else if (!(memWEN && same_word)) begin
                    ren          = 1'b1;
                    r_state_next = R_CAP;
                end
            end
            R_CAP:   r_state_next = R_RESP;
            R_RESP:  if (RREADY) r_state_next = R_IDLE;
            default: r_state_next = R_IDLE;
        endcase
    end

    // Read state register with registered ARREADY.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= R_IDLE;
            ARREADY <= 1'b0;
        end else begin
            r_state <= r_state_next;
            ARREADY <= (r_state_next == R_IDLE);
        end
    end

    // Read datapath: capture address, load memory data or the error response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ar_addr <= '0;
            RDATA   <= '0;
            RRESP   <= RESP_OKAY;
        end else begin
            if (ar_fire) ar_addr <= ARADDR;
            if (r_state == R_MEM && !ar_in_range) begin
                RDATA <= '0;
                RRESP <= RESP_SLVERR;
            end
            if (r_state == R_CAP) begin
                RDATA <= memRDATA;
                RRESP <= RESP_OKAY;
            end
        end
    end

    assign RVALID    = (r_state == R_RESP);
    assign memREN    = ren;
    assign memARADDR = ar_addr;

endmodule

// File: tb/tb_axi4lite_ctrl.sv
// Bench for axi4lite_ctrl with a read-before-write byte-strobed memory model
// beside the DUT and queue-based expected responses.
module tb_axi4lite_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        AWVALID = 1'b0, AWREADY;
    logic [11:0] AWADDR = '0;
    logic        WVALID = 1'b0, WREADY;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        BVALID, BREADY = 1'b0;
    logic [1:0]  BRESP;
    logic        ARVALID = 1'b0, ARREADY;
    logic [11:0] ARADDR = '0;
    logic        RVALID, RREADY = 1'b0;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        memWEN, memREN;
    logic [11:0] memAWADDR, memARADDR;
    logic [3:0]  memWSTRB;
    logic [31:0] memWDATA;
    logic [31:0] memRDATA = '0;

    axi4lite_ctrl #(.addrWidth(12), .dataWidth(32), .strbWidth(4), .memBytes(1024)) dut (
        .clk(clk), .reset(reset),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
        .memWEN(memWEN), .memAWADDR(memAWADDR), .memWSTRB(memWSTRB), .memWDATA(memWDATA),
        .memREN(memREN), .memARADDR(memARADDR), .memRDATA(memRDATA)
    );

    always #5 clk = ~clk;

    // Memory beside the controller: registered read of the old contents.
    logic [31:0] mem [256] = '{default: '0};
    int unsigned cyc = 0, wen_cnt = 0, ren_cnt = 0, wen_cyc = 0, ren_cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (memREN) begin
            memRDATA <= mem[memARADDR[9:2]];
            ren_cnt  <= ren_cnt + 1;
            ren_cyc  <= cyc;
        end
        if (memWEN) begin
            for (int b = 0; b < 4; b++)
                if (memWSTRB[b]) mem[memAWADDR[9:2]][8*b +: 8] <= memWDATA[8*b +: 8];
            wen_cnt <= wen_cnt + 1;
            wen_cyc <= cyc;
        end
    end

    // Reference model and scoreboard queues.
    logic [31:0] ref_mem [256] = '{default: '0};
    logic [1:0]  bq [$];
    logic [33:0] rq [$];
    int unsigned total = 0, bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic expect_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb);
        if (addr < 12'd1024) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) ref_mem[addr[9:2]][8*b +: 8] = data[8*b +: 8];
            bq.push_back(2'b00);
        end else begin
            bq.push_back(2'b10);
        end
    endtask

    task automatic expect_read(input logic [11:0] addr);
        if (addr < 12'd1024) rq.push_back({2'b00, ref_mem[addr[9:2]]});
        else                 rq.push_back({2'b10, 32'h0});
    endtask

    task automatic send_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bit a_done = 1'b0, w_done = 1'b0, a_hs, w_hs;
        AWADDR = addr; WDATA = data; WSTRB = strb;
        AWVALID = 1'b1; WVALID = 1'b1;
        for (int i = 0; i < 20 && !(a_done && w_done); i++) begin
            a_hs = AWVALID && AWREADY;
            w_hs = WVALID && WREADY;
            @(negedge clk);
            if (a_hs) begin AWVALID = 1'b0; a_done = 1'b1; end
            if (w_hs) begin WVALID = 1'b0; w_done = 1'b1; end
        end
        AWVALID = 1'b0; WVALID = 1'b0;
        check("aw_w_accept", 64'({a_done, w_done}), 64'h3);
    endtask

    task automatic send_read(input logic [11:0] addr);
        bit done = 1'b0, hs;
        ARADDR = addr; ARVALID = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            hs = ARVALID && ARREADY;
            @(negedge clk);
            if (hs) begin ARVALID = 1'b0; done = 1'b1; end
        end
        ARVALID = 1'b0;
        check("ar_accept", 64'(done), 64'h1);
    endtask

    task automatic recv_b(input int stall);
        logic [1:0] first, exp;
        for (int n = 0; n < 20 && !BVALID; n++) @(negedge clk);
        check("bvalid_seen", 64'(BVALID), 64'h1);
        first = BRESP;
        for (int i = 0; i < stall; i++) begin
            AWVALID = 1'b1;
            @(negedge clk);
            check("bvalid_hold", 64'(BVALID), 64'h1);
            check("bresp_hold", 64'(BRESP), 64'(first));
            check("awready_stall", 64'(AWREADY), 64'h0);
        end
        AWVALID = 1'b0;
        BREADY = 1'b1;
        exp = (bq.size() > 0) ? bq.pop_front() : 2'bxx;
        check("bresp", 64'(BRESP), 64'(exp));
        @(negedge clk);
        BREADY = 1'b0;
        check("bvalid_drop", 64'(BVALID), 64'h0);
    endtask

    task automatic recv_r(input int stall);
        logic [33:0] first, exp;
        for (int n = 0; n < 20 && !RVALID; n++) @(negedge clk);
        check("rvalid_seen", 64'(RVALID), 64'h1);
        first = {RRESP, RDATA};
        for (int i = 0; i < stall; i++) begin
            ARVALID = 1'b1;
            @(negedge clk);
            check("rvalid_hold", 64'(RVALID), 64'h1);
            check("rresp_rdata_hold", 64'({RRESP, RDATA}), 64'(first));
            check("arready_stall", 64'(ARREADY), 64'h0);
        end
        ARVALID = 1'b0;
        RREADY = 1'b1;
        exp = (rq.size() > 0) ? rq.pop_front() : 34'bx;
        check("rresp", 64'(RRESP), 64'(exp[33:32]));
        check("rdata", 64'(RDATA), 64'(exp[31:0]));
        @(negedge clk);
        RREADY = 1'b0;
        check("rvalid_drop", 64'(RVALID), 64'h0);
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb, input int stall);
        expect_write(addr, data, strb);
        send_write(addr, data, strb);
        recv_b(stall);
    endtask

    task automatic rd(input logic [11:0] addr, input int stall);
        expect_read(addr);
        send_read(addr);
        recv_r(stall);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 64'({AWREADY, WREADY, ARREADY}), 64'h0);
        check({tag, "_valid"}, 64'({BVALID, RVALID}), 64'h0);
        check({tag, "_memen"}, 64'({memWEN, memREN}), 64'h0);
        check({tag, "_resp"}, 64'({BRESP, RRESP}), 64'h0);
        check({tag, "_rdata"}, 64'(RDATA), 64'h0);
        check({tag, "_memw"}, 64'({memAWADDR, memWSTRB, memWDATA}), 64'h0);
        check({tag, "_memar"}, 64'(memARADDR), 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned base_w, base_r;

        // Reset state and READY rising on the first edge after release.
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 64'({AWREADY, WREADY, ARREADY}), 64'h7);

        // Same-cycle AW+W with partial strobe, then readback.
        base_w = wen_cnt;
        expect_write(12'd12, 32'h5501_9983, 4'b1011);
        send_write(12'd12, 32'h5501_9983, 4'b1011);
        check("t1_memwen_n1", 64'(memWEN), 64'h1);
        check("t1_memw_fields", 64'({memAWADDR, memWSTRB, memWDATA}), {16'h0, 12'd12, 4'b1011, 32'h5501_9983});
        @(negedge clk);
        check("t1_memwen_n2", 64'(memWEN), 64'h0);
        check("t1_bvalid_n2", 64'(BVALID), 64'h1);
        recv_b(0);
        check("t1_wen_once", 64'(wen_cnt - base_w), 64'h1);
        expect_read(12'd12);
        send_read(12'd12);
        check("t1_memren_n1", 64'(memREN), 64'h1);
        @(negedge clk);
        check("t1_rvalid_n2", 64'(RVALID), 64'h0);
        @(negedge clk);
        check("t1_rvalid_n3", 64'(RVALID), 64'h1);
        check("t1_rdata_const", 64'(RDATA), 64'h5500_9983);
        recv_r(0);

        // W leads AW by three cycles.
        base_w = wen_cnt;
        expect_write(12'h040, 32'h0BAD_F00D, 4'hF);
        WDATA = 32'h0BAD_F00D; WSTRB = 4'hF; WVALID = 1'b1;
        for (int i = 0; i < 20 && !WREADY; i++) @(negedge clk);
        @(negedge clk);
        WVALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("wlead_wready_low", 64'(WREADY), 64'h0);
            check("wlead_no_wen", 64'(memWEN), 64'h0);
            @(negedge clk);
        end
        check("wlead_awready", 64'(AWREADY), 64'h1);
        AWADDR = 12'h040; AWVALID = 1'b1;
        @(negedge clk);
        AWVALID = 1'b0;
        check("wlead_memwen", 64'(memWEN), 64'h1);
        recv_b(0);
        check("wlead_wen_once", 64'(wen_cnt - base_w), 64'h1);
        rd(12'h040, 0);

        // Out-of-range write and read.
        base_w = wen_cnt;
        base_r = ren_cnt;
        wr(12'd1024, 32'h1111_2222, 4'hF, 0);
        check("oor_no_wen", 64'(wen_cnt - base_w), 64'h0);
        expect_read(12'd2000);
        send_read(12'd2000);
        check("oor_no_ren_n1", 64'(memREN), 64'h0);
        @(negedge clk);
        check("oor_rvalid_n2", 64'(RVALID), 64'h1);
        recv_r(0);
        check("oor_no_ren", 64'(ren_cnt - base_r), 64'h0);

        // Same-word write/read collision: read deferred one cycle.
        wr(12'd4, 32'hCAFE_F00D, 4'hF, 0);
        expect_write(12'd8, 32'hDEAD_BEEF, 4'hF);
        expect_read(12'd8);
        fork
            begin send_write(12'd8, 32'hDEAD_BEEF, 4'hF); recv_b(0); end
            begin send_read(12'd8); recv_r(0); end
        join
        check("collide_deferred", 64'(ren_cyc), 64'(wen_cyc + 1));

        // Different-word concurrent access: both issue in the same cycle.
        expect_write(12'd8, 32'h1234_5678, 4'hF);
        expect_read(12'd4);
        fork
            begin send_write(12'd8, 32'h1234_5678, 4'hF); recv_b(0); end
            begin send_read(12'd4); recv_r(0); end
        join
        check("no_collide_same_cycle", 64'(ren_cyc), 64'(wen_cyc));

        // Response back-pressure.
        wr(12'd16, 32'hA5A5_5A5A, 4'hF, 5);
        rd(12'd16, 5);

        // Reset right after AW+W acceptance.
        base_w = wen_cnt;
        check("rst_pre_ready", 64'({AWREADY, WREADY}), 64'h3);
        AWADDR = 12'd20; WDATA = 32'h7777_7777; WSTRB = 4'hF;
        AWVALID = 1'b1; WVALID = 1'b1;
        @(posedge clk);
        #1 reset = 1'b1;
        AWVALID = 1'b0; WVALID = 1'b0;
        @(negedge clk);
        check_all_zero("midrst");
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_no_wen", 64'(wen_cnt - base_w), 64'h0);
        rd(12'd20, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
